// File: rtl/serial_addsub_ctrl.sv
// Nibble-serial add/subtract unit: one 4-bit slice reused LSB nibble first.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module adder4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] total;

    assign total = 5'(a) + 5'(b) + 5'(cin);
    assign sum   = total[3:0];
    assign cout  = total[4];
endmodule

module serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 busy
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic                 ovf
`endif
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          mode_q, mode_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;

    logic [3:0]    s_a, s_b, s_sum;
    logic          s_cout;
    logic          accept;

    assign s_a    = a_q[{idx_q, 2'b00} +: 4];
    assign s_b    = b_q[{idx_q, 2'b00} +: 4] ^ {4{mode_q}};
    assign accept = in_valid && in_ready_q;

    adder4bit u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry_q),
        .sum  (s_sum),
        .cout (s_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        acc_d       = acc_q;
        result_d    = result_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    state_d    = RUN;
                    a_d        = a;
                    b_d        = b;
                    mode_d     = mode;
                    idx_d      = '0;
                    carry_d    = mode;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                acc_d[{idx_q, 2'b00} +: 4] = s_sum;
                carry_d = s_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    result_d    = acc_d;
                    cout_d      = s_cout;
                    // operands agree in sign but the sum's sign differs
                    ovf_d = (a_q[W-1] == (b_q[W-1] ^ mode_q))
                         && (s_sum[3] != a_q[W-1]);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf       = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl with NIBBLES=4.
module tb_serial_addsub_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        cout;
    logic        busy;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic        ovf;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    serial_addsub_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_seen", in_ready, 1);
    endtask

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tm, input logic [15:0] er,
                         input logic ec, input logic eo);
        int n;
        wait_ready();
        a = ta; b = tb_v; mode = tm;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ta; b = 16'h5a5a; mode = ~tm;
        check("busy_run", busy, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 4);
        check("result", result, er);
        check("cout", cout, ec);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("ovf", ovf, eo);
`else
        if (eo === 1'bx) $display("note: unexpected ovf x");
`endif
        @(posedge clk); #1;
        check("ov_drop", out_valid, 0);
        check("idle_rdy", in_ready, 1);
    endtask

    logic [15:0] bb_a [3] = '{16'h00FF, 16'hA000, 16'h4000};
    logic [15:0] bb_b [3] = '{16'h0001, 16'h5000, 16'h4000};
    logic        bb_m [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] bb_r [3] = '{16'h0100, 16'h5000, 16'h8000};
    logic        bb_c [3] = '{1'b0, 1'b1, 1'b0};
    logic        bb_o [3] = '{1'b0, 1'b1, 1'b1};
    int          acc_t [3];

    initial begin
        int n;
        logic seen;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);

        do_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef SERIAL_ADDSUB_OVF_EN
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif

        // backpressure: result parked in DONE while a new request waits
        wait_ready();
        a = 16'h8000; b = 16'h0001; mode = 1'b1;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_latency", n, 4);
        a = 16'h1111; b = 16'h2222; mode = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_result", result, 16'h7FFF);
            check("bp_cout", cout, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
`ifdef SERIAL_ADDSUB_OVF_EN
            check("bp_ovf", ovf, 1);
`endif
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ov", out_valid, 0);
        check("bp_release_rdy", in_ready, 1);
        check("bp_hold_result", result, 16'h7FFF);

        // reset mid-run
        @(negedge clk);
        a = 16'h1357; b = 16'h2468; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mr_busy", busy, 1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mr_result", result, 0);
        check("mr_cout", cout, 0);
        check("mr_busy0", busy, 0);
        check("mr_out_valid", out_valid, 0);
        check("mr_in_ready", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mr_no_valid", seen, 0);
        do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // back-to-back with in_valid held high
        @(negedge clk);
        out_ready = 1'b1;
        a = bb_a[0]; b = bb_b[0]; mode = bb_m[0]; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b2b_rdy", in_ready, 1);
            acc_t[i] = cyc;
            @(posedge clk);
            @(negedge clk);
            if (i < 2) begin
                a = bb_a[i+1]; b = bb_b[i+1]; mode = bb_m[i+1];
            end else begin
                in_valid = 1'b0;
            end
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b2b_result", result, bb_r[i]);
            check("b2b_cout", cout, bb_c[i]);
`ifdef SERIAL_ADDSUB_OVF_EN
            check("b2b_ovf", ovf, bb_o[i]);
`endif
            if (i > 0) check("b2b_spacing", acc_t[i] - acc_t[i-1], 6);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand (operand width W = 4*NIBBLES, legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a request is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a request.
REQ-006 The block SHALL have ports a and b, input, W bits each: the operands.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 selects a+b, 1 selects a-b.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is available.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port result, output, W bits: the sum or difference modulo 2^W.
REQ-011 The block SHALL have port cout, output, 1 bit: the final carry (for subtract, 1 = no borrow, meaning a>=b unsigned).
REQ-012 The block SHALL have port busy, output, 1 bit: high in the RUN state.

Function
REQ-013 The block SHALL instantiate exactly one adder4bit slice and reuse it for every nibble, least-significant nibble first.
- Slice B input: b nibble XOR {4{mode}}.
- Slice Cin: internal carry register, seeded with mode at accept.
REQ-014 The block SHALL implement an FSM with states IDLE, RUN and DONE.
- IDLE -> RUN on in_valid && in_ready.
- RUN -> DONE after NIBBLES cycles.
- DONE -> IDLE on out_ready.
REQ-015 in_ready SHALL be high only in IDLE, out_valid only in DONE, and busy only in RUN.
REQ-016 On accept, the block SHALL register a, b and mode, clear the nibble index to 0 and seed the carry register with mode; later input changes SHALL NOT affect the operation.
REQ-017 In each RUN cycle, the block SHALL write slice Sum into result nibble [index], load slice Cout into the carry register, and increment the index.
REQ-018 Latency: if accept occurs at edge k, out_valid SHALL rise at edge k+NIBBLES; throughput is one operation per NIBBLES+2 cycles when out_ready is held high.
REQ-019 In DONE, result and cout SHALL hold stable until out_ready is sampled high; out_valid SHALL fall at the next edge.
REQ-020 A new request SHALL NOT be accepted in the same cycle as the output handshake; the earliest accept is the first IDLE cycle.
REQ-021 cout SHALL equal the carry register after the last nibble.
REQ-022 While out_valid is low, result and cout SHALL retain their last values.

Reset
REQ-023 While rst_n is low, the block SHALL be in IDLE, and result, cout, out_valid, busy, the carry register and the index SHALL all be 0.
REQ-024 in_ready SHALL be 0 while rst_n is low and SHALL be 1 from the first edge after release.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation immediately and produce no out_valid for it.

Configuration
REQ-026 With macro SERIAL_ADDSUB_OVF_EN defined, the block SHALL add port ovf (output, 1 bit), meaning two's-complement signed overflow.
- ovf = (a[W-1] == b_eff[W-1]) && (result[W-1] != a[W-1]), where b_eff = b XOR {W{mode}}.
- ovf is valid with out_valid, held like result, and reset to 0.
REQ-027 Without SERIAL_ADDSUB_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (NIBBLES=4)
REQ-028 The bench SHALL cover add: a=0x1234, b=0x0FFF, mode=0 -> result=0x2233, cout=0, out_valid exactly 4 cycles after accept.
REQ-029 The bench SHALL cover subtract with borrow: a=0x0005, b=0x0007, mode=1 -> result=0xFFFE, cout=0; and a=0x0007, b=0x0005 -> result=0x0002, cout=1.
REQ-030 The bench SHALL cover wrap: a=0xFFFF, b=0x0001, mode=0 -> result=0x0000, cout=1; with OVF_EN, a=0x7FFF, b=0x0001 -> result=0x8000, ovf=1.
REQ-031 The bench SHALL cover backpressure: out_ready held low for 10 cycles in DONE -> result stable, in_ready=0 throughout, a new in_valid is ignored; out_ready high -> IDLE next cycle.
REQ-032 The bench SHALL cover reset mid-run: rst_n pulsed low 2 cycles after accept -> all outputs 0 immediately, no out_valid; the next request 0x0001+0x0001 -> result 0x0002.
REQ-033 The bench SHALL cover back-to-back operation: in_valid held high with out_ready=1 -> accepts spaced exactly 6 cycles apart, each result correct.
